adc_sar_sequencer: RTL and testbench

Host-side sequencer for the SAR ADC controller: it drives the converter's start line and consumes its ready/result outputs. Conversions are triggered on a programmable period, and each result is captured after the start/ready handshake completes. Results are optionally averaged, then buffered in a small FIFO with a valid/ready stream output for downstream logic.

---
 rtl/adc_sar_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_adc_sar_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sar_sequencer.sv
// adc_sar_sequencer: periodic trigger, start/ready handshake with a SAR ADC,
// result capture, optional averaging and an output FIFO with valid/ready.
// Optional feature macro: ADC_SEQ_AVG_EN (averages 2^AVG_LOG2 captures per push).
module adc_sar_sequencer #(
    parameter int unsigned RESOLUTION = 4,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [15:0]           period_i,
    output logic                  adc_start_o,
    input  logic                  adc_rdy_i,
    input  logic [RESOLUTION-1:0] adc_result_i,
    output logic [RESOLUTION-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overflow_o,
    output logic                  timeout_o,
    output logic                  busy_o
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Elaboration-time parameter sanity checks
    if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg
        $error("AVG_LOG2 must be in 1..4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_RDY,
        S_RELEASE,
        S_CAPTURE
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             per_cnt_q, per_cnt_d, per_last_c;
    logic                    trig_c;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    timeout_q, timeout_d;
    logic                    cap_c;
    logic                    push_c;
    logic [RESOLUTION-1:0]   push_data_c;

    logic [RESOLUTION-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pop_c, full_c, wr_en_c;
    logic                    overflow_q, overflow_d;

    // Period counter: trigger on reaching period-1 (period 0 behaves as 1)
    always_comb begin
        per_cnt_d  = per_cnt_q;
        trig_c     = 1'b0;
        per_last_c = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
        if (!en_i) begin
            per_cnt_d = 16'd0;
        end else if (per_cnt_q >= per_last_c) begin
            trig_c    = 1'b1;
            per_cnt_d = 16'd0;
        end else begin
            per_cnt_d = per_cnt_q + 16'd1;
        end
    end

    // Conversion FSM next state, timeout counter and registered-output decode
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
        cap_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_c) state_d = S_START;
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (adc_rdy_i) begin
                    state_d = S_RELEASE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                cap_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        start_d = (state_d == S_START) || (state_d == S_WAIT_RDY);
        busy_d  = (state_d != S_IDLE);
    end

    // Sequencer state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            per_cnt_q <= 16'd0;
            to_cnt_q  <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            to_cnt_q  <= to_cnt_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ADC_SEQ_AVG_EN
    localparam int unsigned ACC_W = RESOLUTION + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum_c;
    logic [AVG_LOG2-1:0] smp_q, smp_d;

    // Accumulate captures; push the truncated mean after a full group
    always_comb begin
        acc_d       = acc_q;
        smp_d       = smp_q;
        push_c      = 1'b0;
        push_data_c = '0;
        acc_sum_c   = acc_q + ACC_W'(adc_result_i);
        if (cap_c) begin
            if (smp_q == {AVG_LOG2{1'b1}}) begin
                push_c      = 1'b1;
                push_data_c = RESOLUTION'(acc_sum_c >> AVG_LOG2);
                acc_d       = '0;
                smp_d       = '0;
            end else begin
                acc_d = acc_sum_c;
                smp_d = smp_q + AVG_LOG2'(1);
            end
        end
    end

    // Accumulator and sample counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            smp_q <= '0;
        end else begin
            acc_q <= acc_d;
            smp_q <= smp_d;
        end
    end
`else
    // Every capture goes straight to the FIFO
    always_comb begin
        push_c      = cap_c;
        push_data_c = adc_result_i;
    end
`endif

    // FIFO control: a pop in the same cycle frees room for a push into a full FIFO
    always_comb begin
        pop_c      = (cnt_q != '0) && ready_i;
        full_c     = (cnt_q == CNT_W'(FIFO_DEPTH));
        wr_en_c    = push_c && (!full_c || pop_c);
        overflow_d = push_c && full_c && !pop_c;
        wr_d       = wr_en_c ? wr_q + PTR_W'(1) : wr_q;
        rd_d       = pop_c ? rd_q + PTR_W'(1) : rd_q;
        cnt_d      = cnt_q;
        if (wr_en_c && !pop_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!wr_en_c && pop_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_q] <= push_data_c;
            end
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign adc_start_o = start_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;
    assign overflow_o  = overflow_q;
    assign data_o      = mem_q[rd_q];
    assign valid_o     = (cnt_q != '0);

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Bench for adc_sar_sequencer: behavioural ADC plus a transaction-level
// expectation (each completed handshake contributes its result, in order).
`timescale 1ns/1ps
module tb_adc_sar_sequencer;
    localparam int unsigned RES      = 4;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TIMEOUT  = 64;
`ifdef ADC_SEQ_AVG_EN
    localparam int NAVG = 1 << AVG_LOG2;
`else
    localparam int NAVG = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [15:0]    period;
    logic           adc_start;
    logic           adc_rdy = 1'b0;
    logic [RES-1:0] adc_result = '0;
    logic [RES-1:0] data;
    logic           valid;
    logic           ready;
    logic           ovf;
    logic           tmo;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    // ADC model / monitor state
    int  cyc = 0;
    int  hi_len = 0;
    int  lo_len = 0;
    int  last_hi = 0;
    int  min_lo = 1000;
    bit  had_conv = 1'b0;
    int  lat = 1;
    int  lat_min = 1;
    int  lat_max = 1;
    bit  never = 1'b0;
    int  ovf_n = 0;
    int  tmo_n = 0;
    logic [RES-1:0] hs[$];
    int             hs_fall[$];
    logic [RES-1:0] got[$];
    int             got_cyc[$];
    logic [RES-1:0] force_q[$];

    adc_sar_sequencer #(
        .RESOLUTION(RES), .AVG_LOG2(AVG_LOG2), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .period_i(period),
        .adc_start_o(adc_start), .adc_rdy_i(adc_rdy), .adc_result_i(adc_result),
        .data_o(data), .valid_o(valid), .ready_i(ready),
        .overflow_o(ovf), .timeout_o(tmo), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ADC (answers after lat cycles of start) and output monitor
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hi_len   = 0;
            lo_len   = 0;
            had_conv = 1'b0;
            adc_rdy  = 1'b0;
        end else if (adc_start) begin
            if (hi_len == 0) begin
                if (had_conv && lo_len < min_lo) min_lo = lo_len;
                if (force_q.size() > 0) adc_result = force_q.pop_front();
                else adc_result = RES'($urandom_range(0, (1 << RES) - 1));
                lat = int'($urandom_range(lat_min, lat_max));
            end
            hi_len++;
            lo_len = 0;
            if (!never && hi_len >= lat) adc_rdy = 1'b1;
        end else begin
            if (hi_len > 0) begin
                last_hi  = hi_len;
                had_conv = 1'b1;
                if (adc_rdy) begin
                    hs.push_back(adc_result);
                    hs_fall.push_back(cyc);
                end
            end
            hi_len  = 0;
            adc_rdy = 1'b0;
            lo_len++;
        end
        if (valid && ready) begin
            got.push_back(data);
            got_cyc.push_back(cyc);
        end
        if (ovf) ovf_n++;
        if (tmo) tmo_n++;
    end

    // Expected k-th output word: truncated mean of its group of completed handshakes
    function automatic logic [RES-1:0] exp_word(input int k);
        int s = 0;
        for (int i = 0; i < NAVG; i++) s += int'(hs[k * NAVG + i]);
        return RES'(s / NAVG);
    endfunction

    function automatic int n_words();
        return hs.size() / NAVG;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ready = 1'b0; never = 1'b0;
        tick(2);
        hs.delete(); hs_fall.delete(); got.delete(); got_cyc.delete(); force_q.delete();
        ovf_n = 0; tmo_n = 0; min_lo = 1000;
        rst = 1'b0;
    endtask

    task automatic wait_got(input int n, input int bound, output bit ok);
        for (int i = 0; i < bound && got.size() < n; i++) tick(1);
        ok = (got.size() >= n);
    endtask

    task automatic wait_hs(input int n, input int bound, output bit ok);
        for (int i = 0; i < bound && hs.size() < n; i++) tick(1);
        ok = (hs.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (adc_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", adc_start); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", ovf); end
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", tmo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_periodic();
        bit ok;
        do_reset();
        for (int i = 0; i < 8 * NAVG; i++) force_q.push_back(RES'(4'hA));
        lat_min = 6; lat_max = 6; ready = 1'b1; period = 16'd20; en = 1'b1;
        wait_got(4, 20 * NAVG * 6 + 60, ok);
        en = 1'b0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL periodic_wait: got %0d words want 4", got.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (got[i] !== 4'hA) begin n_bad++; $display("FAIL periodic_data%0d: got %h want a", i, got[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_cyc[i+1] - got_cyc[i] != 20 * NAVG) begin
                    n_bad++; $display("FAIL periodic_interval%0d: got %0d want %0d", i, got_cyc[i+1] - got_cyc[i], 20 * NAVG);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_cyc[i] - hs_fall[i * NAVG + NAVG - 1] < 2) begin
                    n_bad++; $display("FAIL periodic_start_low%0d: got %0d cycles want >=2", i, got_cyc[i] - hs_fall[i * NAVG + NAVG - 1]);
                end
            end
        end
        tick(30);
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 8; en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (c % 160 == 0) period = 16'($urandom_range(12, 40));
            ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        en = 1'b0; ready = 1'b1;
        tick(50);
        n_cmp++; if (got.size() != n_words()) begin n_bad++; $display("FAIL random_count: got %0d want %0d", got.size(), n_words()); end
        for (int i = 0; i < got.size() && i < n_words(); i++) begin
            n_cmp++; if (got[i] !== exp_word(i)) begin n_bad++; $display("FAIL random_data%0d: got %h want %h", i, got[i], exp_word(i)); end
        end
        n_cmp++; if (ovf_n != 0) begin n_bad++; $display("FAIL random_overflow: got %0d want 0", ovf_n); end
        n_cmp++; if (tmo_n != 0) begin n_bad++; $display("FAIL random_timeout: got %0d want 0", tmo_n); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        lat_min = 3; lat_max = 3; period = 16'd20; en = 1'b1;
        wait_hs(6 * NAVG, 6 * NAVG * 20 + 60, ok);
        en = 1'b0;
        tick(20);
        n_cmp++; if (!ok || hs.size() != 6 * NAVG) begin n_bad++; $display("FAIL overflow_conversions: got %0d want %0d", hs.size(), 6 * NAVG); end
        n_cmp++; if (ovf_n != 2) begin n_bad++; $display("FAIL overflow_pulses: got %0d want 2", ovf_n); end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL overflow_valid_held: got %b want 1", valid); end
        ready = 1'b1;
        tick(10);
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL overflow_drain_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_word(i)) begin n_bad++; $display("FAIL overflow_order%0d: got %h want %h", i, got[i], exp_word(i)); end
        end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL overflow_empty: got %b want 0", valid); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        never = 1'b1; lat_min = 4; lat_max = 4; ready = 1'b1; period = 16'd100; en = 1'b1;
        for (int i = 0; i < 300 && tmo_n == 0; i++) tick(1);
        n_cmp++; if (tmo_n == 0) begin n_bad++; $display("FAIL timeout_seen: got no pulse want 1"); end
        n_cmp++; if (last_hi != int'(TIMEOUT) + 1) begin n_bad++; $display("FAIL timeout_start_len: got %0d want %0d", last_hi, TIMEOUT + 1); end
        never = 1'b0;
        tick(5);
        n_cmp++; if (tmo_n != 1) begin n_bad++; $display("FAIL timeout_pulses: got %0d want 1", tmo_n); end
        n_cmp++; if (got.size() != 0 || valid !== 1'b0) begin n_bad++; $display("FAIL timeout_no_push: got %0d words want 0", got.size()); end
        wait_got(1, NAVG * 110 + 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout_recover: got %0d words want 1", got.size()); end
        else begin
            n_cmp++; if (got[0] !== exp_word(0)) begin n_bad++; $display("FAIL timeout_recover_data: got %h want %h", got[0], exp_word(0)); end
        end
        en = 1'b0;
        tick(20);
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        lat_min = 2; lat_max = 2; period = 16'd30; en = 1'b1;
        wait_hs(NAVG, NAVG * 30 + 60, ok);
        never = 1'b1;
        for (int i = 0; i < 100 && hi_len < 4; i++) tick(1);
        n_cmp++; if (adc_start !== 1'b1 || busy !== 1'b1 || valid !== 1'b1) begin
            n_bad++; $display("FAIL midreset_pre: got start=%b busy=%b valid=%b want 1 1 1", adc_start, busy, valid);
        end
        rst = 1'b1;
        tick(1);
        n_cmp++; if (adc_start !== 1'b0) begin n_bad++; $display("FAIL midreset_start: got %b want 0", adc_start); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", valid); end
        hs.delete(); hs_fall.delete(); got.delete(); got_cyc.delete();
        never = 1'b0; lat_min = 3; lat_max = 3; ready = 1'b1;
        rst = 1'b0;
        wait_got(1, NAVG * 30 + 80, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midreset_resume: got %0d words want 1", got.size()); end
        else begin
            n_cmp++; if (got[0] !== exp_word(0)) begin n_bad++; $display("FAIL midreset_resume_data: got %h want %h", got[0], exp_word(0)); end
        end
        en = 1'b0;
        tick(20);
    endtask

    task automatic test_back_to_back();
        for (int p = 1; p >= 0; p--) begin
            do_reset();
            lat_min = 10; lat_max = 10; ready = 1'b1; period = 16'(p); en = 1'b1;
            tick(130 * NAVG);
            en = 1'b0;
            tick(30);
            n_cmp++; if (hs.size() < 9 * NAVG) begin n_bad++; $display("FAIL b2b_p%0d_conversions: got %0d want >=%0d", p, hs.size(), 9 * NAVG); end
            n_cmp++; if (min_lo != 3) begin n_bad++; $display("FAIL b2b_p%0d_gap: got %0d want 3", p, min_lo); end
            n_cmp++; if (tmo_n != 0) begin n_bad++; $display("FAIL b2b_p%0d_timeout: got %0d want 0", p, tmo_n); end
            n_cmp++; if (got.size() != n_words()) begin n_bad++; $display("FAIL b2b_p%0d_count: got %0d want %0d", p, got.size(), n_words()); end
            for (int i = 0; i < got.size() && i < n_words(); i++) begin
                n_cmp++; if (got[i] !== exp_word(i)) begin n_bad++; $display("FAIL b2b_p%0d_data%0d: got %h want %h", p, i, got[i], exp_word(i)); end
            end
        end
    endtask

`ifdef ADC_SEQ_AVG_EN
    task automatic test_average();
        bit ok;
        do_reset();
        force_q.push_back(4'd3); force_q.push_back(4'd4); force_q.push_back(4'd5); force_q.push_back(4'd6);
        lat_min = 2; lat_max = 2; ready = 1'b1; period = 16'd20; en = 1'b1;
        wait_hs(3, 100, ok);
        tick(3);
        n_cmp++; if (!ok || got.size() != 0) begin n_bad++; $display("FAIL avg_early_push: got %0d words want 0", got.size()); end
        wait_got(1, 60, ok);
        en = 1'b0;
        n_cmp++; if (!ok || got[0] !== 4'd4) begin n_bad++; $display("FAIL avg_value: got %0d words want one word of 4"); end
        tick(40);
        n_cmp++; if (got.size() != 1) begin n_bad++; $display("FAIL avg_single_push: got %0d want 1", got.size()); end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; period = 16'd0; ready = 1'b0;
        test_reset();
        test_periodic();
        test_random();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef ADC_SEQ_AVG_EN
        test_average();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
